tl45_memory: RTL and testbench

TL45_MEMORY -- requirements
Module: tl45_memory

---
 rtl/tl45_pkg.sv | 26 ++
 rtl/tl45_memory.sv | 190 +++++++++++++++++++
 tb/tb_tl45_memory.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl45_pkg.sv
// Shared types for the TL45 memory stage: operation codes and FSM states.
package tl45_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    HOLD
  } mem_state_t;

  // Encoding 3 is reserved and behaves as a plain pass-through.
  function automatic mem_op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_op = LOAD;
      2'd2:    decode_op = STORE;
      default: decode_op = NONE;
    endcase
  endfunction

endpackage

// File: rtl/tl45_memory.sv
// TL45 memory stage: pipeline buffer plus a single-beat Wishbone master with timeout.
// Define TL45_MEM_ALIGN_CHECK_EN to fault misaligned LOAD/STORE without a bus cycle.
module tl45_memory
  import tl45_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  output logic        o_pipe_stall,
  input  logic [1:0]  i_buf_op,
  input  logic [3:0]  i_buf_dr,
  input  logic [31:0] i_buf_val,
  input  logic [31:0] i_buf_sr_val,
  output logic [3:0]  o_buf_dr,
  output logic [31:0] o_buf_val,
  output logic [3:0]  o_fwd_reg,
  output logic [31:0] o_fwd_val,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_fault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mem_state_t       state_q, state_d;
  logic [3:0]       buf_dr_q, buf_dr_d;
  logic [31:0]      buf_val_q, buf_val_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       sel_q, sel_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_dr_q, cap_dr_d;
  logic             cap_load_q, cap_load_d;

  mem_op_t op;
  logic    mem_req;
  logic    misaligned;
  logic    done_ok;
  logic    done_err;

  assign op      = decode_op(i_buf_op);
  assign mem_req = (op == LOAD) || (op == STORE);

`ifdef TL45_MEM_ALIGN_CHECK_EN
  assign misaligned = (i_buf_val[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      buf_dr_q   <= '0;
      buf_val_q  <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      cap_dr_q   <= '0;
      cap_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_dr_q   <= buf_dr_d;
      buf_val_q  <= buf_val_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      cap_dr_q   <= cap_dr_d;
      cap_load_q <= cap_load_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_dr_d   = buf_dr_q;
    buf_val_d  = buf_val_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    fault_d    = 1'b0;
    cnt_d      = cnt_q;
    cap_dr_d   = cap_dr_q;
    cap_load_d = cap_load_q;
    done_ok    = 1'b0;
    done_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!i_pipe_stall) begin
          if (mem_req && misaligned) begin
            buf_dr_d = '0;
            fault_d  = 1'b1;
          end else if (mem_req) begin
            state_d    = STROBE;
            cyc_d      = 1'b1;
            stb_d      = 1'b1;
            we_d       = (op == STORE);
            addr_d     = i_buf_val[31:2];
            data_d     = i_buf_sr_val;
            sel_d      = '1;
            cnt_d      = '0;
            cap_dr_d   = i_buf_dr;
            cap_load_d = (op == LOAD);
            buf_dr_d   = '0;
          end else begin
            buf_dr_d  = i_buf_dr;
            buf_val_d = i_buf_val;
          end
        end
      end
      STROBE: begin
        buf_dr_d = '0;
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT_ACK;
          if (i_wb_err)      done_err = 1'b1;
          else if (i_wb_ack) done_ok  = 1'b1;
        end
      end
      WAIT_ACK: begin
        buf_dr_d = '0;
        if (i_wb_err)               done_err = 1'b1;
        else if (i_wb_ack)          done_ok  = 1'b1;
        else if (cnt_q >= CNT_LAST) done_err = 1'b1;
        else if (cnt_q != '1)       cnt_d    = cnt_q + 1'b1;
      end
      HOLD: begin
        if (!i_pipe_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion is shared by STROBE (same-cycle ack) and WAIT_ACK.
    if (done_ok || done_err) begin
      state_d = i_pipe_stall ? HOLD : IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      if (done_err) begin
        buf_dr_d = '0;
        fault_d  = 1'b1;
      end else if (cap_load_q) begin
        buf_dr_d  = cap_dr_q;
        buf_val_d = i_wb_data;
      end else begin
        buf_dr_d = '0;
      end
    end
  end

  assign o_pipe_stall = i_pipe_stall || (state_q != IDLE) || ((state_q == IDLE) && mem_req);
  assign o_buf_dr     = buf_dr_q;
  assign o_buf_val    = buf_val_q;
  assign o_fwd_reg    = buf_dr_q;
  assign o_fwd_val    = buf_val_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = we_q;
  assign o_wb_addr    = addr_q;
  assign o_wb_data    = data_q;
  assign o_wb_sel     = sel_q;
  assign o_fault      = fault_q;

endmodule

// File: tb/tb_tl45_memory.sv
// Self-checking bench for tl45_memory: pass-through vector table plus bus sequences.
module tb_tl45_memory;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst_n;
  logic        ps_in;
  logic        ps_out;
  logic [1:0]  op;
  logic [3:0]  dr;
  logic [31:0] val;
  logic [31:0] sr;
  logic [3:0]  buf_dr;
  logic [31:0] buf_val;
  logic [3:0]  fwd_reg;
  logic [31:0] fwd_val;
  logic        cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack, wstall, err;
  logic [31:0] rdata;
  logic        fault;

  tl45_memory #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_pipe_stall(ps_in), .o_pipe_stall(ps_out),
    .i_buf_op(op), .i_buf_dr(dr), .i_buf_val(val), .i_buf_sr_val(sr),
    .o_buf_dr(buf_dr), .o_buf_val(buf_val),
    .o_fwd_reg(fwd_reg), .o_fwd_val(fwd_val),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr),
    .o_wb_data(wdata), .o_wb_sel(sel),
    .i_wb_ack(ack), .i_wb_stall(wstall), .i_wb_err(err), .i_wb_data(rdata),
    .o_fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  dr;
    logic [31:0] val;
    logic        fault;
    logic        chk_val;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  dr;
    logic [31:0] val;
    logic        ps;
    logic [3:0]  e_dr;
    logic [31:0] e_val;
    logic        e_stall;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [31:0] v, input logic f, input logic cv);
    exp_t e;
    e.dr = d; e.val = v; e.fault = f; e.chk_val = cv;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got dr=%h", name, buf_dr);
    end else begin
      e = sb.pop_front();
      chk({name, "_dr"}, 32'(buf_dr), 32'(e.dr));
      chk({name, "_fwd_reg"}, 32'(fwd_reg), 32'(e.dr));
      chk({name, "_fault"}, 32'(fault), 32'(e.fault));
      if (e.chk_val) begin
        chk({name, "_val"}, buf_val, e.val);
        chk({name, "_fwd_val"}, fwd_val, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    op = 2'd0; dr = '0; val = '0; sr = '0;
    ack = 1'b0; err = 1'b0; wstall = 1'b0; rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd0, 4'd3,  32'h0000_1234, 1'b0, 4'd3,  32'h0000_1234, 1'b0};
    vt[1] = '{2'd0, 4'd7,  32'hFFFF_FFFF, 1'b0, 4'd7,  32'hFFFF_FFFF, 1'b0};
    vt[2] = '{2'd0, 4'd9,  32'h0000_A5A5, 1'b1, 4'd7,  32'hFFFF_FFFF, 1'b1};
    vt[3] = '{2'd3, 4'd2,  32'h0000_0055, 1'b0, 4'd2,  32'h0000_0055, 1'b0};
    vt[4] = '{2'd0, 4'd0,  32'h0000_0000, 1'b0, 4'd0,  32'h0000_0000, 1'b0};
    vt[5] = '{2'd0, 4'd15, 32'h8000_0001, 1'b0, 4'd15, 32'h8000_0001, 1'b0};

    rst_n = 1'b0; ps_in = 1'b0;
    idle_inputs();
    #12;
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_buf_dr", 32'(buf_dr), 0);
    chk("rst_buf_val", buf_val, 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_pstall", 32'(ps_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pass-through vectors
    for (int i = 0; i < 6; i++) begin
      op = vt[i].op; dr = vt[i].dr; val = vt[i].val; ps_in = vt[i].ps;
      #1;
      chk("vec_pstall", 32'(ps_out), 32'(vt[i].e_stall));
      push(vt[i].e_dr, vt[i].e_val, 1'b0, 1'b1);
      step();
      pop_check("vec");
      chk("vec_cyc", 32'(cyc), 0);
    end

    // LOAD with two slave-stall cycles, ack one cycle after strobe accepted
    op = 2'd1; dr = 4'd5; val = 32'h100; wstall = 1'b1;
    #1;
    chk("ld_pstall_req", 32'(ps_out), 1);
    push(4'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step();
    chk("ld_cyc", 32'(cyc), 1);
    chk("ld_stb", 32'(stb), 1);
    chk("ld_addr", 32'(addr), 32'h40);
    chk("ld_we", 32'(we), 0);
    chk("ld_sel", 32'(sel), 32'hF);
    chk("ld_bubble", 32'(buf_dr), 0);
    op = 2'd0; dr = '0; val = '0;
    #1;
    chk("ld_pstall_strobe", 32'(ps_out), 1);
    step();
    chk("ld_stb_hold", 32'(stb), 1);
    chk("ld_addr_hold", 32'(addr), 32'h40);
    wstall = 1'b0;
    step();
    chk("ld_stb_drop", 32'(stb), 0);
    chk("ld_cyc_wait", 32'(cyc), 1);
    chk("ld_addr_wait", 32'(addr), 32'h40);
    chk("ld_pstall_wait", 32'(ps_out), 1);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    ack = 1'b0; rdata = '0;
    chk("ld_cyc_done", 32'(cyc), 0);
    pop_check("ld");
    chk("ld_pstall_idle", 32'(ps_out), 0);

    // STORE with ack in the strobe cycle
    op = 2'd2; dr = 4'd4; val = 32'h8; sr = 32'h0000_CAFE;
    push(4'd0, 32'h0, 1'b0, 1'b0);
    step();
    chk("st_we", 32'(we), 1);
    chk("st_data", wdata, 32'h0000_CAFE);
    chk("st_sel", 32'(sel), 32'hF);
    chk("st_addr", 32'(addr), 32'h2);
    chk("st_cyc", 32'(cyc), 1);
    op = 2'd0; dr = '0; val = '0; sr = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("st_cyc_done", 32'(cyc), 0);
    chk("st_stb_done", 32'(stb), 0);
    pop_check("st");

    // LOAD with no ack: timeout after TO cycles waiting
    op = 2'd1; dr = 4'd6; val = 32'h20;
    push(4'd0, 32'h0, 1'b1, 1'b0);
    step();
    op = 2'd0; dr = '0; val = '0;
    step();
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_cyc_wait", 32'(cyc), 1);
      chk("to_fault_wait", 32'(fault), 0);
      step();
    end
    chk("to_cyc_drop", 32'(cyc), 0);
    pop_check("to");
    step();
    chk("to_fault_pulse", 32'(fault), 0);

    // ack and err together: err wins
    op = 2'd1; dr = 4'd8; val = 32'h40;
    push(4'd0, 32'h0, 1'b1, 1'b0);
    step();
    op = 2'd0; dr = '0; val = '0;
    step();
    ack = 1'b1; err = 1'b1; rdata = 32'h1111_1111;
    step();
    ack = 1'b0; err = 1'b0; rdata = '0;
    chk("err_cyc", 32'(cyc), 0);
    pop_check("err");

    // LOAD completing while downstream stalls for 3 cycles
    op = 2'd1; dr = 4'd9; val = 32'h44;
    push(4'd9, 32'h1234_5678, 1'b0, 1'b1);
    step();
    op = 2'd0; dr = 4'd1; val = 32'h0000_0BAD;
    step();
    ack = 1'b1; rdata = 32'h1234_5678; ps_in = 1'b1;
    step();
    ack = 1'b0; rdata = '0;
    pop_check("hold");
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_dr", 32'(buf_dr), 9);
      chk("hold_val", buf_val, 32'h1234_5678);
      chk("hold_pstall", 32'(ps_out), 1);
      chk("hold_cyc", 32'(cyc), 0);
    end
    ps_in = 1'b0;
    #1;
    chk("hold_pstall_release", 32'(ps_out), 1);
    step();
    chk("hold_exit_dr", 32'(buf_dr), 9);
    chk("hold_exit_pstall", 32'(ps_out), 0);
    step();
    chk("hold_next_dr", 32'(buf_dr), 1);
    chk("hold_next_val", buf_val, 32'h0000_0BAD);

    // IDLE with downstream stall: LOAD must not start
    ps_in = 1'b1; op = 2'd1; dr = 4'd2; val = 32'h80;
    step();
    chk("istall_cyc", 32'(cyc), 0);
    chk("istall_dr", 32'(buf_dr), 1);
    chk("istall_pstall", 32'(ps_out), 1);
    step();
    chk("istall_cyc2", 32'(cyc), 0);
    ps_in = 1'b0; op = 2'd0; dr = '0; val = '0;
    step();

    // Reset asserted while waiting for ack
    op = 2'd1; dr = 4'd7; val = 32'h200;
    step();
    op = 2'd0; dr = '0; val = '0;
    step();
    chk("rw_cyc_before", 32'(cyc), 1);
    rst_n = 1'b0;
    #1;
    chk("rw_cyc", 32'(cyc), 0);
    chk("rw_stb", 32'(stb), 0);
    chk("rw_addr", 32'(addr), 0);
    chk("rw_sel", 32'(sel), 0);
    chk("rw_buf_dr", 32'(buf_dr), 0);
    chk("rw_pstall", 32'(ps_out), 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    op = 2'd0; dr = 4'd3; val = 32'h77;
    push(4'd3, 32'h77, 1'b0, 1'b1);
    step();
    pop_check("post_rst");

`ifdef TL45_MEM_ALIGN_CHECK_EN
    op = 2'd1; dr = 4'd5; val = 32'h3;
    push(4'd0, 32'h0, 1'b1, 1'b0);
    step();
    op = 2'd0; dr = '0; val = '0;
    chk("align_cyc", 32'(cyc), 0);
    pop_check("align");
    step();
    chk("align_fault_pulse", 32'(fault), 0);
`else
    op = 2'd1; dr = 4'd5; val = 32'h103;
    push(4'd5, 32'hA5A5_A5A5, 1'b0, 1'b1);
    step();
    chk("unal_cyc", 32'(cyc), 1);
    chk("unal_addr", 32'(addr), 32'h40);
    chk("unal_fault", 32'(fault), 0);
    op = 2'd0; dr = '0; val = '0;
    ack = 1'b1; rdata = 32'hA5A5_A5A5;
    step();
    ack = 1'b0; rdata = '0;
    pop_check("unal");
`endif

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
